// File: rtl/axis_traffic_gen.sv
// axis_traffic_gen
// AXI4-Stream packet generator. A run is launched by a start pulse. It sends
// cfg_pkt_count packets of cfg_pkt_len beats each, with cfg_gap idle cycles
// between packets. A cfg_pkt_count of 0 keeps the run going until a stop is
// requested. tdata carries a 32-bit running beat counter. tuser marks the
// first beat of each packet and tlast marks the final beat.
// A stop never cuts a packet short: it takes effect at the next tlast transfer,
// or at once when the generator is sitting in an inter-packet gap.
module axis_traffic_gen #(
  parameter int C_AXIS_DATA_WIDTH = 32,
  parameter int C_AXIS_ID_WIDTH   = 4,
  parameter int C_AXIS_DEST_WIDTH = 4
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           aclken,
  input  logic                           start,
  input  logic                           stop,
  input  logic [15:0]                    cfg_pkt_len,
  input  logic [15:0]                    cfg_pkt_count,
  input  logic [7:0]                     cfg_gap,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] cfg_last_keep,
  input  logic [C_AXIS_ID_WIDTH-1:0]     cfg_tid,
  input  logic [C_AXIS_DEST_WIDTH-1:0]   cfg_tdest,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                           m_axis_tlast,
  output logic [C_AXIS_ID_WIDTH-1:0]     m_axis_tid,
  output logic [C_AXIS_DEST_WIDTH-1:0]   m_axis_tdest,
  output logic                           m_axis_tuser,
  output logic                           busy,
  output logic                           done,
  output logic [15:0]                    pkts_sent
);

  localparam int KW = C_AXIS_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t                 state_q, state_d;

  // Configuration captured when the run starts. Zero lengths and zero last-keep
  // values are normalised once here, so the datapath never has to handle them.
  logic [15:0]            len_q, len_d;
  logic [15:0]            count_q, count_d;
  logic [7:0]             gap_q, gap_d;
  logic [KW-1:0]          last_keep_q, last_keep_d;
  logic [C_AXIS_ID_WIDTH-1:0]   tid_q, tid_d;
  logic [C_AXIS_DEST_WIDTH-1:0] tdest_q, tdest_d;

  // Run progress
  logic [15:0]            beat_q, beat_d;       // beat index inside current packet
  logic [31:0]            data_cnt_q, data_cnt_d; // running beat counter for tdata
  logic [15:0]            pkts_q, pkts_d;       // packets completed this run
  logic [7:0]             gap_cnt_q, gap_cnt_d; // remaining idle cycles in GAP
  logic                   stop_pend_q, stop_pend_d;
  logic                   done_q, done_d;

  logic                   is_last;
  logic                   run_end;
  logic [C_AXIS_DATA_WIDTH-1:0] data_ext;

  // Current beat is the final beat of its packet
  assign is_last = (beat_q == (len_q - 16'd1));

  // The run finishes at this tlast when a stop is pending (or arrives now), or
  // when this packet brings the count up to a nonzero target
  assign run_end = stop_pend_q || stop ||
                   ((count_q != 16'd0) && ((pkts_q + 16'd1) == count_q));

  // Fit the 32-bit beat counter to the bus width, by zero-extending or by truncating
  generate
    if (C_AXIS_DATA_WIDTH > 32) begin : g_data_wide
      assign data_ext = {{(C_AXIS_DATA_WIDTH-32){1'b0}}, data_cnt_q};
    end else begin : g_data_narrow
      assign data_ext = data_cnt_q[C_AXIS_DATA_WIDTH-1:0];
    end
  endgenerate

  // Next-state logic: every register holds its value unless aclken allows progress
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    count_d     = count_q;
    gap_d       = gap_q;
    last_keep_d = last_keep_q;
    tid_d       = tid_q;
    tdest_d     = tdest_q;
    beat_d      = beat_q;
    data_cnt_d  = data_cnt_q;
    pkts_d      = pkts_q;
    gap_cnt_d   = gap_cnt_q;
    stop_pend_d = stop_pend_q;
    done_d      = done_q;

    if (aclken) begin
      done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A stop on its own is ignored here. A stop that arrives together with
          // start is remembered, so the run ends after its first packet.
          if (start) begin
            state_d     = ST_SEND;
            len_d       = (cfg_pkt_len == 16'd0) ? 16'd1 : cfg_pkt_len;
            count_d     = cfg_pkt_count;
            gap_d       = cfg_gap;
            last_keep_d = (cfg_last_keep == '0) ? {KW{1'b1}} : cfg_last_keep;
            tid_d       = cfg_tid;
            tdest_d     = cfg_tdest;
            beat_d      = 16'd0;
            data_cnt_d  = 32'd0;
            pkts_d      = 16'd0;
            gap_cnt_d   = 8'd0;
            stop_pend_d = stop;
          end
        end

        ST_SEND: begin
          if (stop) begin
            stop_pend_d = 1'b1;
          end
          if (m_axis_tready) begin
            data_cnt_d = data_cnt_q + 32'd1;
            if (is_last) begin
              pkts_d = pkts_q + 16'd1;
              beat_d = 16'd0;
              if (run_end) begin
                state_d     = ST_IDLE;
                done_d      = 1'b1;
                stop_pend_d = 1'b0;
              end else if (gap_q != 8'd0) begin
                state_d   = ST_GAP;
                gap_cnt_d = gap_q;
              end
            end else begin
              beat_d = beat_q + 16'd1;
            end
          end
        end

        ST_GAP: begin
          // Nothing is in flight during a gap, so a stop can end the run at once
          if (stop) begin
            state_d     = ST_IDLE;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
            gap_cnt_d   = 8'd0;
          end else if (gap_cnt_q <= 8'd1) begin
            state_d   = ST_SEND;
            gap_cnt_d = 8'd0;
          end else begin
            gap_cnt_d = gap_cnt_q - 8'd1;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State register; reset clears everything and overrides aclken
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      len_q       <= 16'd0;
      count_q     <= 16'd0;
      gap_q       <= 8'd0;
      last_keep_q <= '0;
      tid_q       <= '0;
      tdest_q     <= '0;
      beat_q      <= 16'd0;
      data_cnt_q  <= 32'd0;
      pkts_q      <= 16'd0;
      gap_cnt_q   <= 8'd0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      count_q     <= count_d;
      gap_q       <= gap_d;
      last_keep_q <= last_keep_d;
      tid_q       <= tid_d;
      tdest_q     <= tdest_d;
      beat_q      <= beat_d;
      data_cnt_q  <= data_cnt_d;
      pkts_q      <= pkts_d;
      gap_cnt_q   <= gap_cnt_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
    end
  end

  // Stream outputs come only from registers, so they stay stable until a
  // transfer happens. Outside SEND they are forced to zero.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tstrb  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    m_axis_tid    = '0;
    m_axis_tdest  = '0;
    if (state_q == ST_SEND) begin
      m_axis_tvalid = 1'b1;
      m_axis_tdata  = data_ext;
      m_axis_tlast  = is_last;
      m_axis_tuser  = (beat_q == 16'd0);
      m_axis_tkeep  = is_last ? last_keep_q : {KW{1'b1}};
      m_axis_tstrb  = is_last ? last_keep_q : {KW{1'b1}};
      m_axis_tid    = tid_q;
      m_axis_tdest  = tdest_q;
    end
  end

  // done_q holds its value while aclken is low. The pulse is therefore shown
  // during exactly one enabled cycle.
  assign done      = done_q & aclken;
  assign busy      = (state_q != ST_IDLE);
  assign pkts_sent = pkts_q;

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Testbench for axis_traffic_gen: directed runs, checked against a
// beat-queue model of the expected stream plus literal expectations.
module tb_axis_traffic_gen;

  localparam int DW = 32;
  localparam int KW = 4;

  logic          clk;
  logic          areset, aclken, start, stop;
  logic [15:0]   cfg_pkt_len, cfg_pkt_count;
  logic [7:0]    cfg_gap;
  logic [KW-1:0] cfg_last_keep;
  logic [3:0]    cfg_tid, cfg_tdest;
  logic          tvalid, tready, tlast, tuser;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep, tstrb;
  logic [3:0]    tid, tdest;
  logic          busy, done;
  logic [15:0]   pkts_sent;

  axis_traffic_gen #(
    .C_AXIS_DATA_WIDTH(DW),
    .C_AXIS_ID_WIDTH(4),
    .C_AXIS_DEST_WIDTH(4)
  ) dut (
    .aclk(clk), .areset(areset), .aclken(aclken), .start(start), .stop(stop),
    .cfg_pkt_len(cfg_pkt_len), .cfg_pkt_count(cfg_pkt_count), .cfg_gap(cfg_gap),
    .cfg_last_keep(cfg_last_keep), .cfg_tid(cfg_tid), .cfg_tdest(cfg_tdest),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
    .m_axis_tstrb(tstrb), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast),
    .m_axis_tid(tid), .m_axis_tdest(tdest), .m_axis_tuser(tuser),
    .busy(busy), .done(done), .pkts_sent(pkts_sent)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        user;
    logic [3:0]  keep;
    logic [3:0]  id;
    logic [3:0]  dest;
  } beat_t;

  beat_t       exp_q[$];
  int          xfer_cyc[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          n_last = 0;
  int          n_user = 0;
  logic [31:0] m_data = 32'd0;
  logic [31:0] last_data = 32'd0;
  logic [3:0]  last_keep_seen = 4'd0;
  logic        prev_stall = 1'b0;
  logic [49:0] snap = '0;
  logic [49:0] cur;
  int          done_base;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: the stream a run must produce, one packet after another
  task automatic push_pkts(input int npk, input int len, input logic [3:0] keep,
                           input logic [3:0] id, input logic [3:0] dest);
    int l = (len == 0) ? 1 : len;
    logic [3:0] k = (keep == 4'd0) ? 4'hF : keep;
    for (int p = 0; p < npk; p++) begin
      for (int b = 0; b < l; b++) begin
        beat_t e;
        e.data = m_data;
        e.last = (b == l - 1);
        e.user = (b == 0);
        e.keep = (b == l - 1) ? k : 4'hF;
        e.id   = id;
        e.dest = dest;
        exp_q.push_back(e);
        m_data = m_data + 32'd1;
      end
    end
  endtask

  task automatic new_run();
    m_data = 32'd0;
    exp_q.delete();
    xfer_cyc.delete();
    n_last = 0;
    n_user = 0;
    done_base = done_cnt;
  endtask

  task automatic do_start(input int len, input int count, input int gap,
                          input logic [3:0] keep, input logic [3:0] id,
                          input logic [3:0] dest, input logic stp);
    cfg_pkt_len   = 16'(len);
    cfg_pkt_count = 16'(count);
    cfg_gap       = 8'(gap);
    cfg_last_keep = keep;
    cfg_tid       = id;
    cfg_tdest     = dest;
    start = 1'b1;
    stop  = stp;
    tick(1);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick(1);
      k++;
    end
    chk("wait_idle", 64'(busy), 64'd0);
  endtask

  task automatic wait_xfer(input int n, input int budget);
    int k = 0;
    while (xfer_cyc.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    chk("wait_xfer", 64'(xfer_cyc.size() >= n), 64'd1);
  endtask

  // Compare process: at every negedge, check the presented beat against the
  // model, check stability while stalled, and record transfers and done pulses
  initial begin
    forever begin
      logic fire;
      @(negedge clk);
      fire = tvalid && tready && aclken && !areset;
      cur  = {tdata, tkeep, tstrb, tlast, tuser, tid, tdest};
      if (prev_stall) begin
        chk("valid_held", 64'(tvalid), 64'd1);
        chk("payload_stable", 64'(cur), 64'(snap));
      end
      if (tvalid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 64'd1, 64'd0);
        end else begin
          chk("tdata", 64'(tdata), 64'(exp_q[0].data));
          chk("tlast", 64'(tlast), 64'(exp_q[0].last));
          chk("tuser", 64'(tuser), 64'(exp_q[0].user));
          chk("tkeep", 64'(tkeep), 64'(exp_q[0].keep));
          chk("tstrb", 64'(tstrb), 64'(exp_q[0].keep));
          chk("tid", 64'(tid), 64'(exp_q[0].id));
          chk("tdest", 64'(tdest), 64'(exp_q[0].dest));
          if (fire) begin
            last_data = tdata;
            if (tlast) begin
              n_last++;
              last_keep_seen = tkeep;
            end
            if (tuser) n_user++;
            xfer_cyc.push_back(cyc);
            void'(exp_q.pop_front());
          end
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = (tvalid === 1'b1) && !fire && !areset;
      snap = cur;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1; aclken = 1'b1; start = 1'b0; stop = 1'b0; tready = 1'b1;
    cfg_pkt_len = 16'd0; cfg_pkt_count = 16'd0; cfg_gap = 8'd0;
    cfg_last_keep = 4'd0; cfg_tid = 4'd0; cfg_tdest = 4'd0;
    done_base = 0;
    tick(3);
    // Reset state
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_tkeep", 64'(tkeep), 64'd0);
    chk("rst_tstrb", 64'(tstrb), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_tuser", 64'(tuser), 64'd0);
    chk("rst_tid", 64'(tid), 64'd0);
    chk("rst_tdest", 64'(tdest), 64'd0);
    chk("rst_pkts", 64'(pkts_sent), 64'd0);
    areset = 1'b0;
    tick(2);

    // 4-beat packets, two of them, back to back
    new_run();
    push_pkts(2, 4, 4'd0, 4'h3, 4'h5);
    do_start(4, 2, 0, 4'd0, 4'h3, 4'h5, 1'b0);
    chk("t1_latency_tvalid", 64'(tvalid), 64'd1);
    chk("t1_first_tdata", 64'(tdata), 64'd0);
    wait_idle(100);
    tick(2);
    chk("t1_nbeats", 64'(xfer_cyc.size()), 64'd8);
    if (xfer_cyc.size() == 8) begin
      for (int i = 1; i < 8; i++) chk("t1_back2back", 64'(xfer_cyc[i] - xfer_cyc[0]), 64'(i));
      chk("t1_done_time", 64'(done_cyc - xfer_cyc[7]), 64'd1);
    end
    chk("t1_done_cnt", 64'(done_cnt - done_base), 64'd1);
    chk("t1_pkts", 64'(pkts_sent), 64'd2);
    chk("t1_last_data", 64'(last_data), 64'd7);
    chk("t1_n_last", 64'(n_last), 64'd2);
    chk("t1_n_user", 64'(n_user), 64'd2);
    chk("t1_exp_left", 64'(exp_q.size()), 64'd0);

    // 3-beat packets with a 2-cycle gap; a second start while busy is ignored
    new_run();
    push_pkts(2, 3, 4'd0, 4'h1, 4'h2);
    do_start(3, 2, 2, 4'd0, 4'h1, 4'h2, 1'b0);
    wait_xfer(1, 20);
    cfg_pkt_len = 16'd7; cfg_tid = 4'h9;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_idle(100);
    tick(2);
    chk("t2_nbeats", 64'(xfer_cyc.size()), 64'd6);
    if (xfer_cyc.size() == 6) begin
      chk("t2_b1", 64'(xfer_cyc[1] - xfer_cyc[0]), 64'd1);
      chk("t2_b2", 64'(xfer_cyc[2] - xfer_cyc[1]), 64'd1);
      chk("t2_gap", 64'(xfer_cyc[3] - xfer_cyc[2]), 64'd3);
      chk("t2_b4", 64'(xfer_cyc[4] - xfer_cyc[3]), 64'd1);
    end
    chk("t2_done_cnt", 64'(done_cnt - done_base), 64'd1);
    chk("t2_pkts", 64'(pkts_sent), 64'd2);
    chk("t2_last_data", 64'(last_data), 64'd5);
    chk("t2_exp_left", 64'(exp_q.size()), 64'd0);

    // tready toggling with a partial last keep
    new_run();
    push_pkts(2, 2, 4'b0011, 4'h6, 4'h7);
    tready = 1'b1;
    do_start(2, 2, 0, 4'b0011, 4'h6, 4'h7, 1'b0);
    for (int i = 0; i < 60 && busy; i++) begin
      tready = ~tready;
      tick(1);
    end
    tready = 1'b1;
    wait_idle(50);
    tick(2);
    chk("t3_nbeats", 64'(xfer_cyc.size()), 64'd4);
    chk("t3_last_keep", 64'(last_keep_seen), 64'd3);
    chk("t3_n_last", 64'(n_last), 64'd2);
    chk("t3_pkts", 64'(pkts_sent), 64'd2);
    chk("t3_exp_left", 64'(exp_q.size()), 64'd0);

    // Continuous run, stop on beat 1 finishes the packet
    new_run();
    push_pkts(1, 5, 4'd0, 4'h2, 4'h3);
    do_start(5, 0, 0, 4'd0, 4'h2, 4'h3, 1'b0);
    wait_xfer(1, 20);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    wait_idle(50);
    tick(10);
    chk("t4_nbeats", 64'(xfer_cyc.size()), 64'd5);
    chk("t4_last_data", 64'(last_data), 64'd4);
    chk("t4_n_last", 64'(n_last), 64'd1);
    chk("t4_done_cnt", 64'(done_cnt - done_base), 64'd1);
    chk("t4_pkts", 64'(pkts_sent), 64'd1);
    chk("t4_tvalid", 64'(tvalid), 64'd0);

    // Reset during beat 2, then restart from tdata 0
    new_run();
    push_pkts(1, 8, 4'd0, 4'h4, 4'h4);
    do_start(8, 0, 0, 4'd0, 4'h4, 4'h4, 1'b0);
    wait_xfer(2, 20);
    areset = 1'b1;
    tick(1);
    areset = 1'b0;
    chk("t5_tvalid", 64'(tvalid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_pkts", 64'(pkts_sent), 64'd0);
    exp_q.delete();
    tick(3);
    chk("t5_no_done", 64'(done_cnt - done_base), 64'd0);
    chk("t5_n_last", 64'(n_last), 64'd0);
    new_run();
    push_pkts(1, 2, 4'd0, 4'h4, 4'h4);
    do_start(2, 1, 0, 4'd0, 4'h4, 4'h4, 1'b0);
    chk("t5_restart_tdata", 64'(tdata), 64'd0);
    wait_idle(50);
    tick(2);
    chk("t5_last_data", 64'(last_data), 64'd1);
    chk("t5_pkts_after", 64'(pkts_sent), 64'd1);

    // aclken low for 3 cycles mid-packet
    new_run();
    push_pkts(1, 4, 4'd0, 4'h8, 4'h1);
    do_start(4, 1, 0, 4'd0, 4'h8, 4'h1, 1'b0);
    wait_xfer(2, 20);
    aclken = 1'b0;
    tick(3);
    chk("t6_frozen_beats", 64'(xfer_cyc.size()), 64'd2);
    chk("t6_frozen_tdata", 64'(tdata), 64'd2);
    chk("t6_frozen_tvalid", 64'(tvalid), 64'd1);
    aclken = 1'b1;
    wait_idle(50);
    tick(2);
    chk("t6_nbeats", 64'(xfer_cyc.size()), 64'd4);
    chk("t6_pkts", 64'(pkts_sent), 64'd1);

    // aclken low for 3 cycles inside a 2-cycle gap
    new_run();
    push_pkts(2, 2, 4'd0, 4'h1, 4'h1);
    do_start(2, 2, 2, 4'd0, 4'h1, 4'h1, 1'b0);
    wait_xfer(2, 20);
    aclken = 1'b0;
    tick(3);
    aclken = 1'b1;
    wait_idle(50);
    tick(2);
    chk("t7_nbeats", 64'(xfer_cyc.size()), 64'd4);
    if (xfer_cyc.size() == 4) chk("t7_gap_frozen", 64'(xfer_cyc[2] - xfer_cyc[1]), 64'd6);
    chk("t7_pkts", 64'(pkts_sent), 64'd2);

    // Stop during a gap ends the run at once
    new_run();
    push_pkts(1, 2, 4'd0, 4'h5, 4'h6);
    do_start(2, 0, 5, 4'd0, 4'h5, 4'h6, 1'b0);
    wait_xfer(2, 20);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("t8_busy", 64'(busy), 64'd0);
    chk("t8_tvalid", 64'(tvalid), 64'd0);
    tick(8);
    chk("t8_done_cnt", 64'(done_cnt - done_base), 64'd1);
    chk("t8_pkts", 64'(pkts_sent), 64'd1);
    chk("t8_exp_left", 64'(exp_q.size()), 64'd0);

    // start and stop together send exactly one packet
    new_run();
    push_pkts(1, 3, 4'd0, 4'hA, 4'hB);
    do_start(3, 0, 0, 4'd0, 4'hA, 4'hB, 1'b1);
    wait_idle(50);
    tick(5);
    chk("t9_nbeats", 64'(xfer_cyc.size()), 64'd3);
    chk("t9_pkts", 64'(pkts_sent), 64'd1);
    chk("t9_done_cnt", 64'(done_cnt - done_base), 64'd1);
    chk("t9_exp_left", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_traffic_gen.md
AXIS_TRAFFIC_GEN -- requirements
Module: axis_traffic_gen

Interface
REQ-001 SHALL provide parameter C_AXIS_DATA_WIDTH, default 32, tdata width in bits; legal values are multiples of 8 from 8 to 512.
REQ-002 SHALL provide parameter C_AXIS_ID_WIDTH, default 4, tid width; legal values 1-8.
REQ-003 SHALL provide parameter C_AXIS_DEST_WIDTH, default 4, tdest width; legal values 1-8.
REQ-004 aclk  in  1  sole clock; all logic on rising edge.
REQ-005 areset  in  1  reset, synchronous and active-high.
REQ-006 aclken  in  1  clock enable; low freezes all state and outputs.
REQ-007 start  in  1  single-cycle pulse that begins a run.
REQ-008 stop  in  1  pulse requesting a graceful halt.
REQ-009 cfg_pkt_len  in  16  beats per packet.
REQ-010 cfg_pkt_count  in  16  packets per run; 0 means continuous.
REQ-011 cfg_gap  in  8  idle cycles between packets.
REQ-012 cfg_last_keep  in  C_AXIS_DATA_WIDTH/8  tkeep for the last beat.
REQ-013 cfg_tid / cfg_tdest  in  ID/DEST width  stream routing fields.
REQ-014 m_axis_tvalid, tready(in), tdata, tstrb, tkeep, tlast, tid, tdest, tuser(1 bit)  AXI4-Stream master feeding the downstream VIP slave port.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 done  out  1  single-cycle pulse at the end of a run.
REQ-017 pkts_sent  out  16  packets completed in the current run; wraps at 65535 -> 0.

Function
REQ-018 SHALL implement FSM states IDLE, SEND and GAP.
REQ-019 IDLE->SEND SHALL occur on start sampled high; all cfg_* inputs are latched on that edge, and pkts_sent and the beat index are cleared.
REQ-020 m_axis_tvalid SHALL rise in the cycle after start is sampled (latency 1).
REQ-021 start while busy SHALL be ignored.
REQ-022 A beat SHALL transfer only on the aclk edge where tvalid, tready and aclken are all high.
REQ-023 Once tvalid is asserted, it and all payload signals SHALL stay stable until that beat transfers.
REQ-024 tdata SHALL carry a 32-bit running beat counter, zero-extended or truncated to C_AXIS_DATA_WIDTH; the counter starts at 0 on start, increments per transferred beat, continues across packets, and wraps at 2^32.
REQ-025 tuser SHALL be 1 on the first beat of each packet and 0 otherwise.
REQ-026 tlast SHALL be 1 on beat cfg_pkt_len-1 of the packet; cfg_pkt_len=0 SHALL be treated as 1.
REQ-027 tkeep SHALL be all ones on non-last beats and cfg_last_keep on the last beat; cfg_last_keep=0 SHALL be treated as all ones.
REQ-028 tstrb SHALL equal tkeep.
REQ-029 tid and tdest SHALL carry the latched config values on every beat.
REQ-030 When the tlast beat transfers, pkts_sent SHALL increment in that same cycle.
REQ-031 SEND->GAP SHALL occur on tlast transfer when cfg_gap>0 and the run is not ending; tvalid SHALL stay low for exactly cfg_gap aclken-qualified cycles, then GAP->SEND.
REQ-032 With cfg_gap=0, the next packet SHALL start back-to-back, with tvalid staying high across the boundary.
REQ-033 The run SHALL end on the tlast transfer when pkts_sent+1 equals cfg_pkt_count (nonzero), or when a stop request is pending.
REQ-034 On run end, the next state SHALL be IDLE, tvalid SHALL go low, and done SHALL pulse for one cycle.
REQ-035 stop SHALL be latched as a pending request.
REQ-036 A pending stop SHALL never truncate a packet: it takes effect at the next tlast transfer.
REQ-037 stop in GAP SHALL go to IDLE immediately with a done pulse.
REQ-038 stop in IDLE SHALL be ignored.
REQ-039 Simultaneous start and stop in IDLE SHALL start a run and latch the stop, so exactly one packet is sent.
REQ-040 With aclken low, there SHALL be no state, counter or gap progress, and done SHALL be held low.

Reset
REQ-041 areset high at an edge SHALL force IDLE, with tvalid, tlast, tuser, busy and done at 0, tdata, tkeep, tstrb, tid and tdest at 0, pkts_sent at 0, the beat counter at 0 and the pending stop cleared.
REQ-042 areset SHALL take priority over aclken and over all other inputs.
REQ-043 Reset mid-packet SHALL drop tvalid after the edge with no tlast emitted, and no done pulse SHALL be produced.

Verification
REQ-044 pkt_len=4, pkt_count=2, gap=0, tready=1 -> 8 consecutive beats with tdata 0..7; tlast on beats 3 and 7; tuser on beats 0 and 4; done 1 cycle after beat 7; pkts_sent=2.
REQ-045 pkt_len=3, gap=2, pkt_count=2, tready=1 -> tvalid low for exactly 2 cycles between beat 2 and beat 3.
REQ-046 Width 32, pkt_len=2, last_keep=4'b0011, tready toggling 1010... -> payload held stable while stalled; beat 1 has tkeep=tstrb=0011.
REQ-047 pkt_count=0, stop asserted on beat 1 of pkt_len=5 -> packet completes through beat 4 with tlast, then IDLE and a done pulse; no further tvalid.
REQ-048 areset during beat 2 of pkt_len=8 -> next cycle tvalid=0, busy=0, pkts_sent=0; a following start restarts tdata at 0.
REQ-049 aclken held low for 3 cycles mid-packet with tready=1 -> no beats transfer, and tdata and gap count are unchanged until aclken returns.
